// File: rtl/alarm_trigger.sv
// Alarm trigger: stores a validated alarm time, rings on the rising edge of a time match,
// and runs ring/snooze countdowns driven by the one-second tick.
module alarm_trigger #(
    parameter int RING_SEC   = 30,
    parameter int SNOOZE_SEC = 10,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       MCLK,
    input  logic       RESET,
    input  logic       tick_1s,
    input  logic       alarm_en,
    input  logic       set_active,
    input  logic       commit,
    input  logic [3:0] alarm_min10,
    input  logic [3:0] alarm_min01,
    input  logic [3:0] alarm_sec10,
    input  logic [3:0] alarm_sec01,
    input  logic [3:0] cur_min10,
    input  logic [3:0] cur_min01,
    input  logic [3:0] cur_sec10,
    input  logic [3:0] cur_sec01,
    input  logic       snooze,
    input  logic       dismiss,
    output logic [1:0] state,
    output logic       ringing,
    output logic       buzzer,
    output logic [1:0] snooze_cnt,
    output logic [5:0] remain_sec,
    output logic       alarm_valid
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ARMED  = 2'b01,
        S_RING   = 2'b10,
        S_SNOOZE = 2'b11
    } state_t;

    localparam logic [5:0] RING_V   = 6'(RING_SEC);
    localparam logic [5:0] SNOOZE_V = 6'(SNOOZE_SEC);
    localparam logic [1:0] MAX_V    = 2'(MAX_SNOOZE);

    state_t     st, st_nx;
    logic [3:0] a_m10, a_m01, a_s10, a_s01;
    logic [5:0] remain_nx;
    logic [1:0] cnt_nx;
    logic       buz_nx;
    logic       commit_ok, eq, eq_d, match, stop, in_alarm;

    assign commit_ok = commit && (alarm_min10 <= 4'd5) && (alarm_min01 <= 4'd9)
                              && (alarm_sec10 <= 4'd5) && (alarm_sec01 <= 4'd9);
    assign eq        = alarm_valid && (a_m10 == cur_min10) && (a_m01 == cur_min01)
                                   && (a_s10 == cur_sec10) && (a_s01 == cur_sec01);
    assign match     = eq && !eq_d;
    assign in_alarm  = (st == S_RING) || (st == S_SNOOZE);
    // A valid commit while the alarm is sounding doubles as a dismiss.
    assign stop      = dismiss || commit_ok;

    always_comb begin
        st_nx     = st;
        remain_nx = remain_sec;
        cnt_nx    = snooze_cnt;
        buz_nx    = buzzer;
        if (!alarm_en) begin
            st_nx     = S_IDLE;
            remain_nx = '0;
            cnt_nx    = '0;
            buz_nx    = 1'b0;
        end else begin
            case (st)
                S_IDLE: st_nx = S_ARMED;
                S_ARMED: begin
                    if (match && !set_active) begin
                        st_nx     = S_RING;
                        remain_nx = RING_V;
                        buz_nx    = 1'b1;
                    end
                end
                S_RING: begin
                    if (stop || (tick_1s && !snooze && remain_sec <= 6'd1)) begin
                        st_nx     = S_ARMED;
                        remain_nx = '0;
                        cnt_nx    = '0;
                        buz_nx    = 1'b0;
                    end else if (snooze) begin
                        // An exhausted snooze still swallows a coincident tick.
                        if (snooze_cnt < MAX_V) begin
                            st_nx     = S_SNOOZE;
                            remain_nx = SNOOZE_V;
                            cnt_nx    = snooze_cnt + 2'd1;
                            buz_nx    = 1'b0;
                        end
                    end else if (tick_1s) begin
                        remain_nx = remain_sec - 6'd1;
                        buz_nx    = !buzzer;
                    end
                end
                S_SNOOZE: begin
                    if (stop) begin
                        st_nx     = S_ARMED;
                        remain_nx = '0;
                        cnt_nx    = '0;
                        buz_nx    = 1'b0;
                    end else if (tick_1s && !snooze) begin
                        if (remain_sec <= 6'd1) begin
                            st_nx     = S_RING;
                            remain_nx = RING_V;
                            buz_nx    = 1'b1;
                        end else begin
                            remain_nx = remain_sec - 6'd1;
                        end
                    end
                end
                default: st_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge MCLK or negedge RESET) begin
        if (!RESET) begin
            st          <= S_IDLE;
            remain_sec  <= '0;
            snooze_cnt  <= '0;
            buzzer      <= 1'b0;
            alarm_valid <= 1'b0;
            a_m10       <= '0;
            a_m01       <= '0;
            a_s10       <= '0;
            a_s01       <= '0;
            eq_d        <= 1'b0;
        end else begin
            st         <= st_nx;
            remain_sec <= remain_nx;
            snooze_cnt <= cnt_nx;
            buzzer     <= buz_nx;
            if (commit_ok) begin
                a_m10       <= alarm_min10;
                a_m01       <= alarm_min01;
                a_s10       <= alarm_sec10;
                a_s01       <= alarm_sec01;
                alarm_valid <= 1'b1;
            end
            // Pre-set the edge detector so a commit-dismiss cannot retrigger on its own new value.
            eq_d <= (commit_ok && in_alarm) ? 1'b1 : eq;
        end
    end

    assign state   = st;
    assign ringing = (st == S_RING);

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed-vector bench for alarm_trigger with RING_SEC=5, SNOOZE_SEC=3, MAX_SNOOZE=2.
module tb_alarm_trigger;

    logic       MCLK = 1'b0;
    logic       RESET, tick_1s, alarm_en, set_active, commit, snooze, dismiss;
    logic [3:0] alarm_min10, alarm_min01, alarm_sec10, alarm_sec01;
    logic [3:0] cur_min10, cur_min01, cur_sec10, cur_sec01;
    logic [1:0] state, snooze_cnt;
    logic       ringing, buzzer, alarm_valid;
    logic [5:0] remain_sec;

    int vectors = 0;
    int errors  = 0;

    alarm_trigger #(.RING_SEC(5), .SNOOZE_SEC(3), .MAX_SNOOZE(2)) dut (
        .MCLK(MCLK), .RESET(RESET), .tick_1s(tick_1s), .alarm_en(alarm_en),
        .set_active(set_active), .commit(commit),
        .alarm_min10(alarm_min10), .alarm_min01(alarm_min01),
        .alarm_sec10(alarm_sec10), .alarm_sec01(alarm_sec01),
        .cur_min10(cur_min10), .cur_min01(cur_min01),
        .cur_sec10(cur_sec10), .cur_sec01(cur_sec01),
        .snooze(snooze), .dismiss(dismiss),
        .state(state), .ringing(ringing), .buzzer(buzzer),
        .snooze_cnt(snooze_cnt), .remain_sec(remain_sec), .alarm_valid(alarm_valid)
    );

    always #5 MCLK = ~MCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge MCLK);
        #1;
    endtask

    task automatic set_cur(input logic [3:0] a, b, c, d);
        cur_min10 = a; cur_min01 = b; cur_sec10 = c; cur_sec01 = d;
    endtask

    task automatic do_commit(input logic [3:0] a, b, c, d);
        alarm_min10 = a; alarm_min01 = b; alarm_sec10 = c; alarm_sec01 = d;
        commit = 1'b1;
        cyc();
        commit = 1'b0;
    endtask

    // cur steps 01:29 -> 01:30, producing a match edge against a stored 01:30
    task automatic trig();
        set_cur(0, 1, 2, 9);
        cyc();
        set_cur(0, 1, 3, 0);
        cyc();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1s = 1'b1;
            cyc();
            tick_1s = 1'b0;
        end
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1;
        cyc();
        snooze = 1'b0;
    endtask

    initial begin
        RESET = 1'b0; tick_1s = 0; alarm_en = 0; set_active = 0; commit = 0;
        snooze = 0; dismiss = 0;
        alarm_min10 = 0; alarm_min01 = 0; alarm_sec10 = 0; alarm_sec01 = 0;
        set_cur(0, 0, 0, 0);
        #1;
        chk("rst_state", state, 0);
        chk("rst_valid", alarm_valid, 0);
        chk("rst_remain", remain_sec, 0);
        chk("rst_buzzer", buzzer, 0);
        cyc(); cyc();
        RESET = 1'b1;

        // no trigger before a valid commit, even at 00:00
        alarm_en = 1'b1;
        cyc();
        chk("idle_to_armed", state, 1);
        cyc(); cyc();
        chk("no_trig_uncommitted", state, 1);

        // basic ring and timeout
        set_cur(0, 1, 2, 9);
        do_commit(0, 1, 3, 0);
        chk("commit_valid", alarm_valid, 1);
        set_cur(0, 1, 3, 0);
        cyc();
        chk("ring_state", state, 2);
        chk("ring_remain", remain_sec, 5);
        chk("ring_buzzer", buzzer, 1);
        chk("ring_flag", ringing, 1);
        ticks(1);
        chk("tick1_remain", remain_sec, 4);
        chk("tick1_buzzer", buzzer, 0);
        ticks(3);
        chk("tick4_remain", remain_sec, 1);
        chk("tick4_buzzer", buzzer, 1);
        ticks(1);
        chk("timeout_state", state, 1);
        chk("timeout_cnt", snooze_cnt, 0);
        chk("timeout_remain", remain_sec, 0);
        cyc();
        chk("no_retrig_level", state, 1);

        // snooze twice, third snooze ignored
        trig();
        chk("retrig", state, 2);
        pulse_snooze();
        chk("snz1_state", state, 3);
        chk("snz1_remain", remain_sec, 3);
        chk("snz1_cnt", snooze_cnt, 1);
        chk("snz1_buzzer", buzzer, 0);
        pulse_snooze();
        chk("snz_in_snooze_ign", remain_sec, 3);
        ticks(2);
        chk("snz1_tick2", remain_sec, 1);
        ticks(1);
        chk("snz1_end_state", state, 2);
        chk("snz1_end_remain", remain_sec, 5);
        pulse_snooze();
        chk("snz2_cnt", snooze_cnt, 2);
        ticks(3);
        chk("snz2_end_state", state, 2);
        pulse_snooze();
        chk("snz3_ignored", ringing, 1);
        chk("snz3_cnt", snooze_cnt, 2);
        chk("snz3_remain", remain_sec, 5);

        // dismiss beats coincident tick
        dismiss = 1'b1; tick_1s = 1'b1;
        cyc();
        dismiss = 1'b0; tick_1s = 1'b0;
        chk("dismiss_state", state, 1);
        chk("dismiss_remain", remain_sec, 0);
        chk("dismiss_cnt", snooze_cnt, 0);
        cyc(); cyc();
        chk("dismiss_no_retrig", state, 1);

        // invalid commit ignored; set_active blocks the match
        do_commit(7, 0, 0, 0);
        chk("bad_commit_valid", alarm_valid, 1);
        set_active = 1'b1;
        trig();
        chk("set_active_block", state, 1);
        cyc();
        set_active = 1'b0;
        cyc();
        chk("no_deferred_trig", state, 1);
        trig();
        chk("stored_kept", state, 2);

        // commit while ringing dismisses and does not retrigger on the new value
        set_cur(0, 2, 0, 0);
        do_commit(0, 2, 0, 0);
        chk("commit_dismiss", state, 1);
        cyc(); cyc();
        chk("commit_no_retrig", state, 1);
        set_cur(0, 1, 5, 9);
        cyc();
        set_cur(0, 2, 0, 0);
        cyc();
        chk("new_value_trig", state, 2);

        // async reset during snooze
        pulse_snooze();
        chk("pre_rst_snooze", state, 3);
        #2 RESET = 1'b0;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_remain", remain_sec, 0);
        chk("async_rst_cnt", snooze_cnt, 0);
        chk("async_rst_valid", alarm_valid, 0);
        cyc();
        RESET = 1'b1;
        chk("post_rst_idle", state, 0);
        cyc();
        chk("post_rst_armed", state, 1);
        chk("post_rst_valid", alarm_valid, 0);

        // alarm_en dropped while ringing
        set_cur(0, 1, 2, 9);
        do_commit(0, 1, 3, 0);
        trig();
        pulse_snooze();
        ticks(3);
        chk("en_drop_pre", snooze_cnt, 1);
        alarm_en = 1'b0;
        cyc();
        chk("en_drop_state", state, 0);
        chk("en_drop_ring", ringing, 0);
        chk("en_drop_cnt", snooze_cnt, 0);
        chk("en_drop_remain", remain_sec, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
